game_flow_fsm: RTL

//  Top-level game sequencer, directly upstream of the VGA menu/overlay renderer.

---
 rtl/game_flow_fsm_pkg.sv | 29 ++
 rtl/game_flow_fsm_if.sv | 31 +++
 rtl/game_flow_fsm_frame_tick_counter.sv | 32 +++
 rtl/game_flow_fsm.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/game_flow_fsm_pkg.sv
// Shared types for the game sequencer: display state codes, result encoding,
// frame-count defaults and counter sizing.
package game_flow_fsm_pkg;

    typedef enum logic [2:0] {
        MENU1P   = 3'b000,
        MENU2P   = 3'b001,
        CNT3     = 3'b010,
        CNT2     = 3'b011,
        CNT1     = 3'b100,
        START    = 3'b101,
        PLAY     = 3'b110,
        GAMEOVER = 3'b111
    } state_t;

    localparam int unsigned COUNT_FRAMES_DEF    = 60;
    localparam int unsigned START_FRAMES_DEF    = 60;
    localparam int unsigned GAMEOVER_FRAMES_DEF = 120;
    localparam int unsigned HP_W_DEF            = 4;

    // Counter holds 0..N-1 for the largest N; never narrower than one bit.
    function automatic int unsigned cnt_width(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/game_flow_fsm_if.sv
// Control/event inputs and renderer-facing outputs of the game sequencer.
interface game_flow_fsm_if #(
    parameter int unsigned HP_W = 4
);
    logic            frame_tick;
    logic            btn_toggle;
    logic            btn_select;
    logic            p1_ko;
    logic            p2_ko;
    logic            round_timeout;
    logic [HP_W-1:0] p1_health;
    logic [HP_W-1:0] p2_health;
    logic [2:0]      state;
    logic            P1win;
    logic            P2win;
    logic            draw;
    logic            two_player;
    logic            round_start;

    modport master (
        output frame_tick, btn_toggle, btn_select, p1_ko, p2_ko, round_timeout,
               p1_health, p2_health,
        input  state, P1win, P2win, draw, two_player, round_start
    );

    modport slave (
        input  frame_tick, btn_toggle, btn_select, p1_ko, p2_ko, round_timeout,
               p1_health, p2_health,
        output state, P1win, P2win, draw, two_player, round_start
    );
endinterface

// File: rtl/game_flow_fsm_frame_tick_counter.sv
// Frame tick counter: counts enabled ticks, pulses done combinationally on the
// tick that hits the terminal count, then wraps to zero.
module frame_tick_counter #(
    parameter int unsigned W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         tick_en,
    input  logic [W-1:0] term,
    output logic         done
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        done  = tick_en && (cnt_q == term);
        cnt_d = cnt_q;
        if (clear || done) begin
            cnt_d = '0;
        end else if (tick_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/game_flow_fsm.sv
// Top-level game sequencer: menu -> countdown -> START -> play -> game over,
// with latched play mode and registered result flags for the renderer.
module game_flow_fsm
    import game_flow_fsm_pkg::*;
#(
    parameter int unsigned COUNT_FRAMES    = COUNT_FRAMES_DEF,
    parameter int unsigned START_FRAMES    = START_FRAMES_DEF,
    parameter int unsigned GAMEOVER_FRAMES = GAMEOVER_FRAMES_DEF,
    parameter int unsigned HP_W            = HP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    game_flow_fsm_if.slave     bus
);
    localparam int unsigned CW = cnt_width(COUNT_FRAMES, START_FRAMES, GAMEOVER_FRAMES);

    state_t          state_q, state_d;
    logic            two_player_q, two_player_d;
    logic            p1win_q, p1win_d;
    logic            p2win_q, p2win_d;
    logic            draw_q, draw_d;
    logic            round_start_q, round_start_d;
    logic            armed_q, armed_d;
    logic            cnt_clear, cnt_en, cnt_done;
    logic [CW-1:0]   cnt_term;
    logic [HP_W-1:0] p1_hp, p2_hp;

    assign p1_hp = bus.p1_health;
    assign p2_hp = bus.p2_health;

    always_comb begin
        cnt_term = '0;
        cnt_en   = 1'b0;
        case (state_q)
            CNT3, CNT2, CNT1: begin
                cnt_term = CW'(COUNT_FRAMES - 1);
                cnt_en   = bus.frame_tick;
            end
            START: begin
                cnt_term = CW'(START_FRAMES - 1);
                cnt_en   = bus.frame_tick;
            end
            GAMEOVER: begin
                cnt_term = CW'(GAMEOVER_FRAMES - 1);
                cnt_en   = bus.frame_tick;
            end
            default: ;
        endcase
    end

    assign cnt_clear = (state_d != state_q);

    frame_tick_counter #(.W(CW)) u_frame_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (cnt_clear),
        .tick_en (cnt_en),
        .term    (cnt_term),
        .done    (cnt_done)
    );

    always_comb begin
        state_d       = state_q;
        two_player_d  = two_player_q;
        p1win_d       = p1win_q;
        p2win_d       = p2win_q;
        draw_d        = draw_q;
        round_start_d = 1'b0;
        armed_d       = armed_q;
        case (state_q)
            MENU1P: begin
                if (bus.btn_select) begin
                    state_d      = CNT3;
                    two_player_d = 1'b0;
                end else if (bus.btn_toggle) begin
                    state_d = MENU2P;
                end
            end
            MENU2P: begin
                if (bus.btn_select) begin
                    state_d      = CNT3;
                    two_player_d = 1'b1;
                end else if (bus.btn_toggle) begin
                    state_d = MENU1P;
                end
            end
            CNT3:  if (cnt_done) state_d = CNT2;
            CNT2:  if (cnt_done) state_d = CNT1;
            CNT1:  if (cnt_done) state_d = START;
            START: begin
                if (cnt_done) begin
                    state_d       = PLAY;
                    round_start_d = 1'b1;
                end
            end
            PLAY: begin
                // KO outranks timeout; the health compare only runs without a KO.
                if (bus.p1_ko || bus.p2_ko || bus.round_timeout) begin
                    state_d = GAMEOVER;
                    if (bus.p1_ko && bus.p2_ko) begin
                        draw_d = 1'b1;
                    end else if (bus.p1_ko) begin
                        p2win_d = 1'b1;
                    end else if (bus.p2_ko) begin
                        p1win_d = 1'b1;
                    end else if (p1_hp > p2_hp) begin
                        p1win_d = 1'b1;
                    end else if (p2_hp > p1_hp) begin
                        p2win_d = 1'b1;
                    end else begin
                        draw_d = 1'b1;
                    end
                end
            end
            GAMEOVER: begin
                if (cnt_done) armed_d = 1'b1;
                if (bus.btn_select && armed_q) begin
                    state_d = MENU1P;
                    p1win_d = 1'b0;
                    p2win_d = 1'b0;
                    draw_d  = 1'b0;
                    armed_d = 1'b0;
                end
            end
            default: state_d = MENU1P;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= MENU1P;
            two_player_q  <= 1'b0;
            p1win_q       <= 1'b0;
            p2win_q       <= 1'b0;
            draw_q        <= 1'b0;
            round_start_q <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            two_player_q  <= two_player_d;
            p1win_q       <= p1win_d;
            p2win_q       <= p2win_d;
            draw_q        <= draw_d;
            round_start_q <= round_start_d;
            armed_q       <= armed_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.P1win       = p1win_q;
    assign bus.P2win       = p2win_q;
    assign bus.draw        = draw_q;
    assign bus.two_player  = two_player_q;
    assign bus.round_start = round_start_q;
endmodule
